mano_sram_ctl: RTL and testbench
================================

Name: mano_sram_ctl

Overview:
- Parametrised synchronous single-port word memory for the Mano-machine datapath: the next generation of the fixed 32x16 RAM.
- Adds configurable width, depth and read latency, plus a selectable read-during-write mode.
- Adds a valid/ready request handshake, a post-reset initialisation sweep and out-of-range address detection.
- Sits between the CPU control unit (AR/DR bus transfers) and main memory storage.

Parameters:
- DATA_W, 16, data word width in bits.
- ADDR_W, 16, address port width in bits.
- DEPTH, 32, number of words implemented. Must satisfy 1 <= DEPTH <= 2**ADDR_W.
- RD_LAT, 1, read latency in cycles from request acceptance to rsp_valid. Legal values are 1 and 2.
- RDW_NEW, 0, read-during-write policy. 0 = old data returned; 1 = new data returned.
- INIT_VAL, 0, word written to every location during the post-reset init sweep.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- we_n  in  1  active-low write select, qualified by req_valid.
- addr  in  ADDR_W  word address.
- data_in  in  DATA_W  write data.
- rd_addr_same  in  1  reserved for future use. Tie to 0; ignored.
- rsp_valid  out  1  read data valid (single-cycle pulse).
- data_out  out  DATA_W  read data. Holds its last value while rsp_valid is low.
- addr_err  out  1  single-cycle pulse: the accepted request addressed a location >= DEPTH.
- init_busy  out  1  init sweep in progress.

Behaviour:
- Reset is asynchronous and active-low. Clock port is clk; reset port is rst_n.
- Values while in reset: req_ready=0, rsp_valid=0, addr_err=0, data_out=0, init_busy=1, init counter=0, read pipeline valid bits cleared.
- State machine has two states:
  - INIT: entered on reset release. Writes INIT_VAL to address cnt each cycle, cnt = 0..DEPTH-1. After writing DEPTH-1 it moves to RUN. The sweep takes exactly DEPTH cycles. init_busy=1 and req_ready=0 throughout.
  - RUN: req_ready=1 every cycle (no internal backpressure). init_busy=0.
  - Asserting rst_n low in any state, including mid-sweep, returns to INIT with the counter at 0. The sweep restarts in full; there is no partial resume.
- A request is accepted on a clock edge where req_valid && req_ready.
- Write (we_n=0), addr < DEPTH: mem[addr] <= data_in at the accept edge. No response is produced.
- Read (we_n=1), addr < DEPTH:
  - RD_LAT=1: data_out and rsp_valid update on the accept edge, so they are visible the cycle after acceptance.
  - RD_LAT=2: one extra output register stage; the response is visible two cycles after acceptance.
- Back-to-back reads are accepted every cycle, and responses come out in order, one per cycle.
- Out-of-range address (addr >= DEPTH; compare on the full ADDR_W value, never truncate):
  - Write: dropped, memory unchanged. addr_err pulses the cycle after acceptance.
  - Read: rsp_valid still pulses with data_out=0. addr_err pulses in the same cycle as rsp_valid.
- Read-during-write: the single port cannot read and write in the same cycle. The RDW_NEW policy applies to a read accepted in the cycle immediately after a write to the same address.
  - For RD_LAT=1 the new data is always returned, whatever RDW_NEW is set to.
  - For RD_LAT=2 with RDW_NEW=1, the read must see the new data. This is naturally satisfied. RDW_NEW is still kept as a forward hook for the dual-port variant.
- Requests presented while init_busy=1 are not accepted. Requesters must hold req_valid until req_ready is high.
- Memory contents are not cleared by reset itself; the init sweep defines them.
- Memory array: DEPTH words x DATA_W bits. Address decode uses addr[$clog2(DEPTH)-1:0] after the range check.

Decomposition:
- Shared package mano_mem_pkg holds:
  - the state encoding typedef (ST_INIT, ST_RUN);
  - the default DATA_W/ADDR_W/DEPTH constants;
  - the RD_LAT legal-value check constant.
- One sub-module, mano_sram_core: the plain array with one write port and one registered read port.
- The handshake, init FSM, range check and latency pipeline live in the top module.

Test Plan:
1. Release rst_n at t0 with DEPTH=32. Expect init_busy=1 and req_ready=0 for exactly 32 cycles, then req_ready=1. Read addr 5: data_out=16'h0000, rsp_valid one cycle later.
2. With RD_LAT=1, write 16'hBEEF to 3, then read 3 in the next cycle. rsp_valid is high and data_out=16'hBEEF one cycle after the read is accepted, with addr_err=0.
3. With RD_LAT=2, issue four back-to-back reads of addrs 0..3 preloaded with 16'h1111..16'h4444. Expect four consecutive rsp_valid pulses starting two cycles after the first accept, carrying the data in order.
4. Write 16'h1234 to addr 40 (DEPTH=32). Expect addr_err to pulse for one cycle, and a subsequent read of addr 8 (same low bits) to return the unchanged 16'h0000. A read of addr 16'hFFFF returns rsp_valid=1, data_out=0, addr_err=1.
5. Assert rst_n low at sweep cycle 10, for less than one clock period. Expect all outputs to go to their reset values immediately (asynchronously), the sweep to restart from 0, and req_ready to rise 32 cycles after release.
6. Hold req_valid with a read of addr 2 during the init sweep. Expect it not to be accepted until req_ready=1. Exactly one rsp_valid is produced, and no response is produced before the sweep ends.

Source files
------------

// File: rtl/mano_mem_pkg.sv
// rtl/mano_mem_pkg.sv - shared state encoding and default geometry for the Mano memory
package mano_mem_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } mem_state_e;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DEPTH  = 32;

  // Largest supported read latency; anything at or above it selects the two-stage pipe.
  localparam int RD_LAT_MAX = 2;

endpackage

// File: rtl/mano_sram_core.sv
// rtl/mano_sram_core.sv - word array with one write port and one registered read port
module mano_sram_core #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read register holds between reads so the top can present a stable data_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mano_sram_ctl.sv
// rtl/mano_sram_ctl.sv - handshake, init sweep, range check and read pipeline around the core
module mano_sram_ctl
  import mano_mem_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DEPTH    = DEF_DEPTH,
  parameter int                RD_LAT   = 1,
  parameter int                RDW_NEW  = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              we_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_addr_same,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              addr_err,
  output logic              init_busy
);

  localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]   LAST    = AW'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  mem_state_e        state, state_nxt;
  logic [AW-1:0]     cnt, cnt_nxt;
  logic              acc, rd_acc, wr_acc, in_rng;
  logic              core_we, core_re;
  logic [AW-1:0]     core_addr;
  logic [DATA_W-1:0] core_wdata, core_rdata, rd1_data;
  logic              v1, rd_err_q, wr_err_q;
  logic              unused_rsvd;

  // Reserved input and the dual-port RDW hook have no effect on a single port.
  assign unused_rsvd = rd_addr_same ^ (RDW_NEW != 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_INIT: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end
      end
      default: ;
    endcase
  end

  assign req_ready = (state == ST_RUN);
  assign init_busy = (state == ST_INIT);

  // Range check on the full address so aliased high addresses are rejected.
  assign in_rng = ({1'b0, addr} < DEPTH_X);
  assign acc    = req_valid & req_ready;
  assign rd_acc = acc & we_n;
  assign wr_acc = acc & ~we_n;

  assign core_we    = init_busy | (wr_acc & in_rng);
  assign core_re    = rd_acc & in_rng;
  assign core_addr  = init_busy ? cnt : addr[AW-1:0];
  assign core_wdata = init_busy ? INIT_VAL : data_in;

  mano_sram_core #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_core (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (core_we),
    .re   (core_re),
    .addr (core_addr),
    .wdata(core_wdata),
    .rdata(core_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      rd_err_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      v1       <= rd_acc;
      wr_err_q <= wr_acc & ~in_rng;
      if (rd_acc) rd_err_q <= ~in_rng;
    end
  end

  // Out-of-range reads skip the array, so force zero over the held read register.
  assign rd1_data = rd_err_q ? '0 : core_rdata;

  if (RD_LAT >= RD_LAT_MAX) begin : g_lat2
    logic              v2, e2;
    logic [DATA_W-1:0] d2;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v2 <= 1'b0;
        e2 <= 1'b0;
        d2 <= '0;
      end else begin
        v2 <= v1;
        e2 <= v1 & rd_err_q;
        if (v1) d2 <= rd1_data;
      end
    end

    assign rsp_valid = v2;
    assign data_out  = d2;
    assign addr_err  = wr_err_q | e2;
  end else begin : g_lat1
    assign rsp_valid = v1;
    assign data_out  = rd1_data;
    assign addr_err  = wr_err_q | (v1 & rd_err_q);
  end

endmodule

// File: tb/tb_mano_sram_ctl.sv
// tb/tb_mano_sram_ctl.sv - directed bench running latency-1 and latency-2 controllers in lockstep
module tb_mano_sram_ctl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        we_n;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        r1_ready, r1_valid, r1_err, r1_busy;
  logic [15:0] r1_dout;
  logic        r2_ready, r2_valid, r2_err, r2_busy;
  logic [15:0] r2_dout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mano_sram_ctl #(.RD_LAT(1), .RDW_NEW(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(r1_ready),
    .we_n(we_n), .addr(addr), .data_in(data_in), .rd_addr_same(1'b0),
    .rsp_valid(r1_valid), .data_out(r1_dout), .addr_err(r1_err), .init_busy(r1_busy)
  );

  mano_sram_ctl #(.RD_LAT(2), .RDW_NEW(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(r2_ready),
    .we_n(we_n), .addr(addr), .data_in(data_in), .rd_addr_same(1'b0),
    .rsp_valid(r2_valid), .data_out(r2_dout), .addr_err(r2_err), .init_busy(r2_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic wn, input logic [15:0] a, input logic [15:0] d);
    req_valid = v;
    we_n      = wn;
    addr      = a;
    data_in   = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 16'h0, 16'h0);
    #3;
    total++;
    if ({r1_ready, r1_valid, r1_err, r1_busy, r1_dout} !== {4'b0001, 16'h0}) begin
      bad++; $display("FAIL reset1 got=%b_%h exp=0001_0000", {r1_ready, r1_valid, r1_err, r1_busy}, r1_dout);
    end
    total++;
    if ({r2_ready, r2_valid, r2_err, r2_busy, r2_dout} !== {4'b0001, 16'h0}) begin
      bad++; $display("FAIL reset2 got=%b_%h exp=0001_0000", {r2_ready, r2_valid, r2_err, r2_busy}, r2_dout);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      total++;
      if ({r1_ready, r1_busy, r2_ready, r2_busy} !== ((k == 32) ? 4'b1010 : 4'b0101)) begin
        bad++; $display("FAIL init_sweep k=%0d got=%b exp=%b", k, {r1_ready, r1_busy, r2_ready, r2_busy},
                        (k == 32) ? 4'b1010 : 4'b0101);
      end
    end
  endtask

  task automatic test_read_after_init();
    drive(1'b1, 1'b1, 16'd5, 16'h0);
    tick();
    drive(1'b0, 1'b1, 16'h0, 16'h0);
    total++;
    if ({r1_valid, r1_err, r1_dout, r2_valid} !== {2'b10, 16'h0000, 1'b0}) begin
      bad++; $display("FAIL rd5_lat1 got v=%b e=%b d=%h v2=%b exp v=1 e=0 d=0000 v2=0", r1_valid, r1_err, r1_dout, r2_valid);
    end
    tick();
    total++;
    if ({r2_valid, r2_err, r2_dout, r1_valid} !== {2'b10, 16'h0000, 1'b0}) begin
      bad++; $display("FAIL rd5_lat2 got v=%b e=%b d=%h v1=%b exp v=1 e=0 d=0000 v1=0", r2_valid, r2_err, r2_dout, r1_valid);
    end
  endtask

  task automatic test_rdw();
    drive(1'b1, 1'b0, 16'd3, 16'hBEEF);
    tick();
    total++;
    if (r1_valid !== 1'b0) begin
      bad++; $display("FAIL wr_no_rsp got=%b exp=0", r1_valid);
    end
    drive(1'b1, 1'b1, 16'd3, 16'h0);
    tick();
    drive(1'b0, 1'b1, 16'h0, 16'h0);
    total++;
    if ({r1_valid, r1_err, r1_dout} !== {2'b10, 16'hBEEF}) begin
      bad++; $display("FAIL rdw_lat1 got v=%b e=%b d=%h exp v=1 e=0 d=beef", r1_valid, r1_err, r1_dout);
    end
    tick();
    total++;
    if ({r2_valid, r2_err, r2_dout} !== {2'b10, 16'hBEEF}) begin
      bad++; $display("FAIL rdw_lat2 got v=%b e=%b d=%h exp v=1 e=0 d=beef", r2_valid, r2_err, r2_dout);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    logic [15:0] e1, e2;
    for (int i = 0; i < 4; i++) begin
      w = 16'(16'h1111 * (i + 1));
      drive(1'b1, 1'b0, 16'(i), w);
      tick();
    end
    drive(1'b1, 1'b1, 16'd0, 16'h0);
    for (int j = 0; j < 6; j++) begin
      tick();
      e1 = 16'(16'h1111 * (j + 1));
      e2 = 16'(16'h1111 * j);
      total++;
      if (r1_valid !== (j < 4) || ((j < 4) && r1_dout !== e1)) begin
        bad++; $display("FAIL b2b_lat1 j=%0d got v=%b d=%h exp v=%b d=%h", j, r1_valid, r1_dout, (j < 4), e1);
      end
      total++;
      if (r2_valid !== (j >= 1 && j <= 4) || ((j >= 1 && j <= 4) && r2_dout !== e2)) begin
        bad++; $display("FAIL b2b_lat2 j=%0d got v=%b d=%h exp v=%b d=%h", j, r2_valid, r2_dout, (j >= 1 && j <= 4), e2);
      end
      if (j + 1 < 4) drive(1'b1, 1'b1, 16'(j + 1), 16'h0);
      else           drive(1'b0, 1'b1, 16'h0, 16'h0);
    end
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 1'b0, 16'd40, 16'h1234);
    tick();
    drive(1'b0, 1'b1, 16'h0, 16'h0);
    total++;
    if ({r1_err, r1_valid, r2_err, r2_valid} !== 4'b1010) begin
      bad++; $display("FAIL oor_wr_err got=%b exp=1010", {r1_err, r1_valid, r2_err, r2_valid});
    end
    tick();
    total++;
    if ({r1_err, r2_err} !== 2'b00) begin
      bad++; $display("FAIL oor_wr_pulse got=%b exp=00", {r1_err, r2_err});
    end
    drive(1'b1, 1'b1, 16'd8, 16'h0);
    tick();
    drive(1'b0, 1'b1, 16'h0, 16'h0);
    total++;
    if ({r1_valid, r1_err, r1_dout} !== {2'b10, 16'h0000}) begin
      bad++; $display("FAIL alias8_lat1 got v=%b e=%b d=%h exp v=1 e=0 d=0000", r1_valid, r1_err, r1_dout);
    end
    tick();
    total++;
    if ({r2_valid, r2_err, r2_dout} !== {2'b10, 16'h0000}) begin
      bad++; $display("FAIL alias8_lat2 got v=%b e=%b d=%h exp v=1 e=0 d=0000", r2_valid, r2_err, r2_dout);
    end
    drive(1'b1, 1'b1, 16'd3, 16'h0);
    tick();
    drive(1'b1, 1'b1, 16'hFFFF, 16'h0);
    total++;
    if ({r1_valid, r1_err, r1_dout} !== {2'b10, 16'h4444}) begin
      bad++; $display("FAIL rd3_lat1 got v=%b e=%b d=%h exp v=1 e=0 d=4444", r1_valid, r1_err, r1_dout);
    end
    tick();
    drive(1'b0, 1'b1, 16'h0, 16'h0);
    total++;
    if ({r1_valid, r1_err, r1_dout} !== {2'b11, 16'h0000}) begin
      bad++; $display("FAIL rdffff_lat1 got v=%b e=%b d=%h exp v=1 e=1 d=0000", r1_valid, r1_err, r1_dout);
    end
    total++;
    if ({r2_valid, r2_err, r2_dout} !== {2'b10, 16'h4444}) begin
      bad++; $display("FAIL rd3_lat2 got v=%b e=%b d=%h exp v=1 e=0 d=4444", r2_valid, r2_err, r2_dout);
    end
    tick();
    total++;
    if ({r2_valid, r2_err, r2_dout, r1_valid, r1_err} !== {2'b11, 16'h0000, 2'b00}) begin
      bad++; $display("FAIL rdffff_lat2 got v=%b e=%b d=%h v1=%b e1=%b exp v=1 e=1 d=0000 v1=0 e1=0",
                      r2_valid, r2_err, r2_dout, r1_valid, r1_err);
    end
  endtask

  task automatic test_mid_sweep_reset();
    drive(1'b1, 1'b1, 16'd1, 16'h0);
    tick();
    drive(1'b0, 1'b1, 16'h0, 16'h0);
    tick();
    total++;
    if ({r1_dout, r2_dout} !== {16'h2222, 16'h2222}) begin
      bad++; $display("FAIL pre_rst_data got=%h/%h exp=2222/2222", r1_dout, r2_dout);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({r1_ready, r1_valid, r1_err, r1_busy, r1_dout, r2_ready, r2_busy, r2_dout} !==
        {4'b0001, 16'h0, 2'b01, 16'h0}) begin
      bad++; $display("FAIL async_rst got r=%b b=%b d=%h r2=%b b2=%b d2=%h exp r=0 b=1 d=0000",
                      r1_ready, r1_busy, r1_dout, r2_ready, r2_busy, r2_dout);
    end
    #1 rst_n = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    total++;
    if ({r1_ready, r1_busy} !== 2'b01) begin
      bad++; $display("FAIL sweep10 got=%b exp=01", {r1_ready, r1_busy});
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({r1_ready, r1_valid, r1_err, r1_busy, r2_ready, r2_valid, r2_busy} !== 7'b0001001) begin
      bad++; $display("FAIL mid_rst got=%b exp=0001001",
                      {r1_ready, r1_valid, r1_err, r1_busy, r2_ready, r2_valid, r2_busy});
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_hold_during_init();
    int n1 = 0;
    int n2 = 0;
    drive(1'b1, 1'b1, 16'd2, 16'h0);
    for (int k = 1; k <= 32; k++) begin
      tick();
      n1 += int'(r1_valid);
      n2 += int'(r2_valid);
      total++;
      if ({r1_ready, r2_ready} !== ((k == 32) ? 2'b11 : 2'b00)) begin
        bad++; $display("FAIL restart_ready k=%0d got=%b exp=%b", k, {r1_ready, r2_ready},
                        (k == 32) ? 2'b11 : 2'b00);
      end
    end
    total++;
    if (n1 != 0 || n2 != 0) begin
      bad++; $display("FAIL early_rsp got=%0d/%0d exp=0/0", n1, n2);
    end
    tick();
    drive(1'b0, 1'b1, 16'h0, 16'h0);
    total++;
    if ({r1_valid, r1_err, r1_dout} !== {2'b10, 16'h0000}) begin
      bad++; $display("FAIL held_rd_lat1 got v=%b e=%b d=%h exp v=1 e=0 d=0000", r1_valid, r1_err, r1_dout);
    end
    tick();
    total++;
    if ({r1_valid, r2_valid, r2_err, r2_dout} !== {3'b010, 16'h0000}) begin
      bad++; $display("FAIL held_rd_lat2 got v1=%b v=%b e=%b d=%h exp v1=0 v=1 e=0 d=0000",
                      r1_valid, r2_valid, r2_err, r2_dout);
    end
    tick();
    total++;
    if ({r1_valid, r2_valid} !== 2'b00) begin
      bad++; $display("FAIL held_rd_single got=%b exp=00", {r1_valid, r2_valid});
    end
  endtask

  initial begin
    test_reset();
    test_read_after_init();
    test_rdw();
    test_back_to_back();
    test_out_of_range();
    test_mid_sweep_reset();
    test_hold_during_init();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
